// File: rtl/instruction_queue.sv
// DEPTH-entry instruction FIFO between fetch and decode, with valid/ready on
// both sides, synchronous flush, and the head word pre-split into fields.
module instruction_queue #(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int DEPTH             = 4,
  parameter int OPCODE_WIDTH      = 5
) (
  input  logic                                      clock,
  input  logic                                      ir_reset,
  input  logic [INSTRUCTION_WIDTH-1:0]              ir_in,
  input  logic                                      ir_in_valid,
  output logic                                      ir_in_ready,
  input  logic                                      ir_flush,
  output logic [INSTRUCTION_WIDTH-1:0]              ir_out,
  output logic                                      ir_out_valid,
  input  logic                                      ir_out_ready,
  output logic [OPCODE_WIDTH-1:0]                   ir_opcode,
  output logic [INSTRUCTION_WIDTH-OPCODE_WIDTH-1:0] ir_operand,
  output logic [$clog2(DEPTH+1)-1:0]                ir_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [INSTRUCTION_WIDTH-1:0] storage_reg [DEPTH];
  logic [PTR_W-1:0]             wr_ptr_reg;
  logic [PTR_W-1:0]             rd_ptr_reg;
  logic [CNT_W-1:0]             count_reg;
  logic [CNT_W-1:0]             count_next;
  logic                         push;
  logic                         pop;

  // Ready depends only on registered occupancy: no consumer-to-producer path.
  assign ir_in_ready  = (count_reg != CNT_W'(DEPTH));
  assign ir_out_valid = (count_reg != '0);
  assign push         = ir_in_valid && ir_in_ready;
  assign pop          = ir_out_valid && ir_out_ready;

  assign ir_out     = ir_out_valid ? storage_reg[rd_ptr_reg] : '0;
  assign ir_opcode  = ir_out[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  assign ir_operand = ir_out[INSTRUCTION_WIDTH-OPCODE_WIDTH-1:0];
  assign ir_count   = count_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock or posedge ir_reset) begin
    if (ir_reset) begin
      for (int i = 0; i < DEPTH; i++) storage_reg[i] <= '0;
    end else if (push && !ir_flush) begin
      storage_reg[wr_ptr_reg] <= ir_in;
    end
  end

  // Flush wins over any push/pop in the same cycle; pointers wrap naturally
  // because DEPTH is a power of two.
  always_ff @(posedge clock or posedge ir_reset) begin
    if (ir_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (ir_flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed-vector bench for instruction_queue with hand-computed expectations.
module tb_instruction_queue;

  logic        clock = 1'b0;
  logic        ir_reset;
  logic [15:0] ir_in;
  logic        ir_in_valid;
  logic        ir_in_ready;
  logic        ir_flush;
  logic [15:0] ir_out;
  logic        ir_out_valid;
  logic        ir_out_ready;
  logic [4:0]  ir_opcode;
  logic [10:0] ir_operand;
  logic [2:0]  ir_count;

  int vec_count = 0;
  int err_count = 0;

  instruction_queue #(
    .INSTRUCTION_WIDTH(16),
    .DEPTH(4),
    .OPCODE_WIDTH(5)
  ) dut (
    .clock(clock),
    .ir_reset(ir_reset),
    .ir_in(ir_in),
    .ir_in_valid(ir_in_valid),
    .ir_in_ready(ir_in_ready),
    .ir_flush(ir_flush),
    .ir_out(ir_out),
    .ir_out_valid(ir_out_valid),
    .ir_out_ready(ir_out_ready),
    .ir_opcode(ir_opcode),
    .ir_operand(ir_operand),
    .ir_count(ir_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    ir_in       = w;
    ir_in_valid = 1'b1;
    step();
    ir_in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] w);
    check(tag, {16'h0, ir_out}, {16'h0, w});
    ir_out_ready = 1'b1;
    step();
    ir_out_ready = 1'b0;
  endtask

  initial begin
    ir_reset     = 1'b1;
    ir_in        = '0;
    ir_in_valid  = 1'b0;
    ir_flush     = 1'b0;
    ir_out_ready = 1'b0;
    step();
    step();
    check("rst_count", {29'h0, ir_count}, 32'd0);
    check("rst_valid", {31'h0, ir_out_valid}, 32'd0);
    check("rst_ready", {31'h0, ir_in_ready}, 32'd1);
    check("rst_out", {16'h0, ir_out}, 32'd0);
    ir_reset = 1'b0;
    step();

    // Fill to full, then a fifth push must be ignored
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    push_word(16'h4444);
    check("full_count", {29'h0, ir_count}, 32'd4);
    check("full_ready", {31'h0, ir_in_ready}, 32'd0);
    check("full_head", {16'h0, ir_out}, 32'h1111);
    push_word(16'h5555);
    check("ovf_count", {29'h0, ir_count}, 32'd4);
    pop_expect("drain0", 16'h1111);
    pop_expect("drain1", 16'h2222);
    pop_expect("drain2", 16'h3333);
    pop_expect("drain3", 16'h4444);
    check("empty_valid", {31'h0, ir_out_valid}, 32'd0);
    check("empty_out", {16'h0, ir_out}, 32'd0);

    // Field split
    push_word(16'hA835);
    check("opcode", {27'h0, ir_opcode}, 32'h15);
    check("operand", {21'h0, ir_operand}, 32'h035);
    pop_expect("split_pop", 16'hA835);
    check("split_count", {29'h0, ir_count}, 32'd0);

    // Steady push+pop at count 2, pointers wrap twice
    push_word(16'h0100);
    push_word(16'h0101);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("pp_head%0d", i), {16'h0, ir_out}, 32'h0100 + i);
      ir_in        = 16'h0102 + 16'(i);
      ir_in_valid  = 1'b1;
      ir_out_ready = 1'b1;
      step();
      check($sformatf("pp_count%0d", i), {29'h0, ir_count}, 32'd2);
    end
    ir_in_valid  = 1'b0;
    ir_out_ready = 1'b0;
    pop_expect("pp_tail0", 16'h010A);
    pop_expect("pp_tail1", 16'h010B);

    // Full plus pop with producer held valid
    push_word(16'h2000);
    push_word(16'h2001);
    push_word(16'h2002);
    push_word(16'h2003);
    ir_in        = 16'h2004;
    ir_in_valid  = 1'b1;
    ir_out_ready = 1'b1;
    step();
    check("fp_count3", {29'h0, ir_count}, 32'd3);
    check("fp_ready", {31'h0, ir_in_ready}, 32'd1);
    ir_out_ready = 1'b0;
    step();
    ir_in_valid = 1'b0;
    check("fp_count4", {29'h0, ir_count}, 32'd4);
    pop_expect("fp_pop0", 16'h2001);
    pop_expect("fp_pop1", 16'h2002);
    pop_expect("fp_pop2", 16'h2003);
    pop_expect("fp_pop3", 16'h2004);

    // Flush beats simultaneous push and pop
    push_word(16'h3000);
    push_word(16'h3001);
    push_word(16'h3002);
    ir_in        = 16'hBEEF;
    ir_in_valid  = 1'b1;
    ir_out_ready = 1'b1;
    ir_flush     = 1'b1;
    step();
    ir_flush    = 1'b0;
    ir_in_valid = 1'b0;
    check("fl_count", {29'h0, ir_count}, 32'd0);
    check("fl_valid", {31'h0, ir_out_valid}, 32'd0);
    check("fl_out", {16'h0, ir_out}, 32'd0);
    // Push with ready high on an empty queue must not lose the word
    push_word(16'h0042);
    check("fl_new_count", {29'h0, ir_count}, 32'd1);
    check("fl_new_out", {16'h0, ir_out}, 32'h0042);
    step();
    ir_out_ready = 1'b0;
    check("fl_new_popped", {29'h0, ir_count}, 32'd0);

    // Asynchronous reset mid-cycle with 3 entries
    push_word(16'h4000);
    push_word(16'h4001);
    push_word(16'h4002);
    check("ar_pre_count", {29'h0, ir_count}, 32'd3);
    #2;
    ir_reset = 1'b1;
    #1;
    check("ar_out", {16'h0, ir_out}, 32'd0);
    check("ar_valid", {31'h0, ir_out_valid}, 32'd0);
    check("ar_count", {29'h0, ir_count}, 32'd0);
    check("ar_ready", {31'h0, ir_in_ready}, 32'd1);
    step();
    ir_reset = 1'b0;
    push_word(16'h0077);
    check("ar_after_out", {16'h0, ir_out}, 32'h0077);
    check("ar_after_count", {29'h0, ir_count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
